// File: rtl/fan_pwm_driver_pkg.sv
// Shared types and helpers for the fan PWM driver: stall FSM states, PWM width,
// saturating increment and the slew-limited ramp step.
package fan_pkg;

  localparam int         PWM_W   = 8;
  localparam logic [7:0] PWM_MAX = 8'd255;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SPINUP = 2'd1,
    ST_RUN    = 2'd2,
    ST_STALL  = 2'd3
  } fan_state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic inc);
    logic [7:0] r;
    if (inc && (v != PWM_MAX)) begin
      r = v + 8'd1;
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Move cur toward tgt by at most step; 9-bit math so neither direction wraps.
  function automatic logic [7:0] ramp_toward(input logic [7:0] cur, input logic [7:0] tgt,
                                             input logic [8:0] step);
    logic [8:0] c;
    logic [8:0] t;
    logic [8:0] r;
    c = {1'b0, cur};
    t = {1'b0, tgt};
    if (t > c) begin
      r = ((t - c) > step) ? (c + step) : t;
    end else begin
      r = ((c - t) > step) ? (c - step) : t;
    end
    return r[7:0];
  endfunction

endpackage

// File: rtl/fan_pwm_driver_if.sv
// Fan-side signal bundle: command/tach in, PWM, duty, tach measurement and stall out.
interface fan_pwm_driver_if;
  import fan_pkg::*;

  logic [PWM_W-1:0] fan_speed;
  logic             fan_tach;
  logic             fan_pwm;
  logic [PWM_W-1:0] duty_current;
  logic [7:0]       tach_count;
  logic             tach_valid;
  logic             fan_stall;

  modport master (
    output fan_speed, fan_tach,
    input  fan_pwm, duty_current, tach_count, tach_valid, fan_stall
  );

  modport slave (
    input  fan_speed, fan_tach,
    output fan_pwm, duty_current, tach_count, tach_valid, fan_stall
  );
endinterface

// File: rtl/fan_pwm_driver_tach_sync_edge.sv
// Two-flop synchronizer for the asynchronous tach pin followed by a registered
// rising-edge pulse.
module tach_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic tach_in,
  output logic edge_pulse
);
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;
  logic edge_q,  edge_d;

  // Next-state for the synchronizer chain and edge detector.
  always_comb begin
    sync1_d = tach_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    edge_d  = sync2_q & ~prev_q;
  end

  // Synchronizer and edge registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      edge_q  <= edge_d;
    end
  end

  assign edge_pulse = edge_q;
endmodule

// File: rtl/fan_pwm_driver.sv
// Slew-limited fan PWM driver with windowed tach measurement and stall detection.
// Optional FAN_STALL_KICK_EN: force fan_pwm high while the stall FSM is in STALL.
module fan_pwm_driver
  import fan_pkg::*;
#(
  parameter int PWM_PRESCALE   = 4,
  parameter int RAMP_STEP      = 8,
  parameter int TACH_WINDOW    = 65536,
  parameter int SPINUP_WINDOWS = 2
) (
  input  logic             clk,
  input  logic             rst,
  fan_pwm_driver_if.slave  bus
);
  localparam int PRE_W = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
  localparam int WIN_W = $clog2(TACH_WINDOW);
  localparam int GR_W  = $clog2(SPINUP_WINDOWS + 1);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PWM_PRESCALE - 1);
  localparam logic [WIN_W-1:0] WIN_MAX = WIN_W'(TACH_WINDOW - 1);
  localparam logic [GR_W-1:0]  GR_MAX  = GR_W'(SPINUP_WINDOWS);

  logic [PRE_W-1:0] presc_q, presc_d;
  logic [7:0]       pwm_cnt_q, pwm_cnt_d;
  logic [7:0]       duty_q, duty_d;
  logic             fan_pwm_q, fan_pwm_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [7:0]       edges_q, edges_d;
  logic [7:0]       tach_count_q, tach_count_d;
  logic             tach_valid_q, tach_valid_d;
  fan_state_t       state_q, state_d;
  logic [GR_W-1:0]  grace_q, grace_d;
  logic             fan_stall_q, fan_stall_d;

  logic       tick;
  logic       period_end;
  logic       win_end;
  logic       edge_pulse;
  logic [7:0] edges_total;

  tach_sync_edge u_tach (
    .clk        (clk),
    .rst        (rst),
    .tach_in    (bus.fan_tach),
    .edge_pulse (edge_pulse)
  );

  // PWM timebase, ramp and PWM compare.
  always_comb begin
    tick       = (presc_q == PRE_MAX);
    presc_d    = tick ? '0 : (presc_q + PRE_W'(1));
    pwm_cnt_d  = tick ? (pwm_cnt_q + 8'd1) : pwm_cnt_q;
    period_end = tick && (pwm_cnt_q == PWM_MAX);
    duty_d     = period_end ? ramp_toward(duty_q, bus.fan_speed, 9'(RAMP_STEP)) : duty_q;
`ifdef FAN_STALL_KICK_EN
    if (state_q == ST_STALL) begin
      fan_pwm_d = 1'b1;
    end else begin
      fan_pwm_d = (duty_q == PWM_MAX) ? 1'b1 : (pwm_cnt_q < duty_q);
    end
`else
    fan_pwm_d = (duty_q == PWM_MAX) ? 1'b1 : (pwm_cnt_q < duty_q);
`endif
  end

  // Tach window: an edge landing in the last cycle still belongs to this window.
  always_comb begin
    win_end     = (win_q == WIN_MAX);
    win_d       = win_end ? '0 : (win_q + WIN_W'(1));
    edges_total = sat_inc(edges_q, edge_pulse);
    if (win_end) begin
      tach_count_d = edges_total;
      tach_valid_d = 1'b1;
      edges_d      = 8'd0;
    end else begin
      tach_count_d = tach_count_q;
      tach_valid_d = 1'b0;
      edges_d      = edges_total;
    end
  end

  // Stall FSM next state; zero duty overrides any window evaluation.
  always_comb begin
    state_d = state_q;
    grace_d = grace_q;
    if (duty_q == 8'd0) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_SPINUP;
          grace_d = '0;
        end
        ST_SPINUP: begin
          if (win_end) begin
            grace_d = grace_q + GR_W'(1);
            if ((grace_q + GR_W'(1)) >= GR_MAX) begin
              state_d = ST_RUN;
            end else begin
              state_d = ST_SPINUP;
            end
          end else begin
            state_d = ST_SPINUP;
          end
        end
        ST_RUN: begin
          if (win_end && (edges_total == 8'd0)) begin
            state_d = ST_STALL;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_STALL: begin
          if (win_end && (edges_total != 8'd0)) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_STALL;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    fan_stall_d = (state_d == ST_STALL);
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q      <= '0;
      pwm_cnt_q    <= 8'd0;
      duty_q       <= 8'd0;
      fan_pwm_q    <= 1'b0;
      win_q        <= '0;
      edges_q      <= 8'd0;
      tach_count_q <= 8'd0;
      tach_valid_q <= 1'b0;
      state_q      <= ST_IDLE;
      grace_q      <= '0;
      fan_stall_q  <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      pwm_cnt_q    <= pwm_cnt_d;
      duty_q       <= duty_d;
      fan_pwm_q    <= fan_pwm_d;
      win_q        <= win_d;
      edges_q      <= edges_d;
      tach_count_q <= tach_count_d;
      tach_valid_q <= tach_valid_d;
      state_q      <= state_d;
      grace_q      <= grace_d;
      fan_stall_q  <= fan_stall_d;
    end
  end

  assign bus.fan_pwm      = fan_pwm_q;
  assign bus.duty_current = duty_q;
  assign bus.tach_count   = tach_count_q;
  assign bus.tach_valid   = tach_valid_q;
  assign bus.fan_stall    = fan_stall_q;
endmodule
